// File: rtl/io_port_ctrl.sv
// io_port_ctrl: NCH-channel IN/OUT port block with strobed input FIFOs.
// Define IO_LOOPBACK_EN to route OUT writes into the matching input FIFO.
module io_port_ctrl #(
  parameter int DATA_W     = 16,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(FIFO_DEPTH),
  localparam int CNTW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*DATA_W-1:0] port_in,
  input  logic [NCH-1:0]        port_in_vld,
`ifdef IO_LOOPBACK_EN
  input  logic [NCH-1:0]        loopback,
`endif
  output logic [NCH*DATA_W-1:0] port_out,
  output logic [NCH-1:0]        port_out_vld,
  input  logic                  cpu_in_req,
  input  logic [CW-1:0]         cpu_in_sel,
  output logic [DATA_W-1:0]     cpu_in_data,
  output logic                  cpu_in_ack,
  output logic                  cpu_in_stall,
  input  logic                  cpu_out_req,
  input  logic [CW-1:0]         cpu_out_sel,
  input  logic [DATA_W-1:0]     cpu_out_data,
  output logic [NCH*CNTW-1:0]   in_count,
  output logic [NCH-1:0]        ovf
);

  logic [NCH-1:0]             inHit;
  logic [NCH-1:0]             outHit;
  logic [NCH-1:0]             empty;
  logic [NCH-1:0]             pop;
  logic [NCH-1:0]             push;
  logic [NCH-1:0][DATA_W-1:0] head;
  logic [NCH-1:0][DATA_W-1:0] pushData;
  logic [DATA_W-1:0]          rdData;
  logic                       rdOk;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [CNTW-1:0]   cnt;
    logic              full;
    logic              accept;
    logic              ovfQ;
    logic [DATA_W-1:0] outQ;
    logic              vldQ;

    assign inHit[c]  = cpu_in_sel == CW'(c);
    assign outHit[c] = cpu_out_req &&
                       cpu_out_sel == CW'(c);
`ifdef IO_LOOPBACK_EN
    assign push[c] = loopback[c] ? outHit[c]
                                 : port_in_vld[c];
    assign pushData[c] = loopback[c] ? cpu_out_data
                       : port_in[c*DATA_W +: DATA_W];
`else
    assign push[c]     = port_in_vld[c];
    assign pushData[c] = port_in[c*DATA_W +: DATA_W];
`endif
    assign empty[c] = cnt == '0;
    assign full     = cnt == CNTW'(FIFO_DEPTH);
    assign pop[c]   = cpu_in_req && inHit[c] && !empty[c];
    // a pop in the same cycle frees a slot for a full FIFO
    assign accept   = push[c] && (!full || pop[c]);
    assign head[c]  = mem[rdPtr];

    always_ff @(posedge clk) begin
      if (accept) mem[wrPtr] <= pushData[c];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wrPtr <= '0;
        rdPtr <= '0;
        cnt   <= '0;
        ovfQ  <= 1'b0;
        outQ  <= '0;
        vldQ  <= 1'b0;
      end else begin
        if (accept) wrPtr <= wrPtr + AW'(1);
        if (pop[c]) rdPtr <= rdPtr + AW'(1);
        cnt  <= cnt + CNTW'(accept) - CNTW'(pop[c]);
        if (push[c] && full && !pop[c]) ovfQ <= 1'b1;
        vldQ <= outHit[c];
        if (outHit[c]) outQ <= cpu_out_data;
      end
    end

    assign in_count[c*CNTW +: CNTW] = cnt;
    assign port_out[c*DATA_W +: DATA_W] = outQ;
    assign port_out_vld[c] = vldQ;
    assign ovf[c] = ovfQ;
  end

  always_comb begin
    rdData = '0;
    for (int i = 0; i < NCH; i++) begin
      if (inHit[i]) rdData = head[i];
    end
  end

  // out-of-range select never stalls and reads back zero
  assign cpu_in_stall = cpu_in_req && |(inHit & empty);
  assign rdOk = cpu_in_req && !cpu_in_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_in_ack  <= 1'b0;
      cpu_in_data <= '0;
    end else begin
      cpu_in_ack <= rdOk;
      if (rdOk) cpu_in_data <= rdData;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: queue-model scoreboard for io_port_ctrl.
// Directed test-plan sequences followed by randomized traffic.
module tb_io_port_ctrl;
  localparam int DATA_W = 16;
  localparam int NCH    = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = 2;
  localparam int CNTW   = 3;

  logic                  clk;
  logic                  reset;
  logic [NCH*DATA_W-1:0] port_in;
  logic [NCH-1:0]        port_in_vld;
`ifdef IO_LOOPBACK_EN
  logic [NCH-1:0]        loopback;
`endif
  logic [NCH*DATA_W-1:0] port_out;
  logic [NCH-1:0]        port_out_vld;
  logic                  cpu_in_req;
  logic [CW-1:0]         cpu_in_sel;
  logic [DATA_W-1:0]     cpu_in_data;
  logic                  cpu_in_ack;
  logic                  cpu_in_stall;
  logic                  cpu_out_req;
  logic [CW-1:0]         cpu_out_sel;
  logic [DATA_W-1:0]     cpu_out_data;
  logic [NCH*CNTW-1:0]   in_count;
  logic [NCH-1:0]        ovf;

  io_port_ctrl #(
    .DATA_W(DATA_W), .NCH(NCH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .port_in(port_in), .port_in_vld(port_in_vld),
`ifdef IO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .port_out(port_out), .port_out_vld(port_out_vld),
    .cpu_in_req(cpu_in_req), .cpu_in_sel(cpu_in_sel),
    .cpu_in_data(cpu_in_data), .cpu_in_ack(cpu_in_ack),
    .cpu_in_stall(cpu_in_stall),
    .cpu_out_req(cpu_out_req), .cpu_out_sel(cpu_out_sel),
    .cpu_out_data(cpu_out_data),
    .in_count(in_count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one queue per input channel
  logic [DATA_W-1:0] q [NCH][$];
  logic [DATA_W-1:0] expQ [$];
  logic [DATA_W-1:0] mOut [NCH];
  logic [NCH-1:0]    mVld = '0;
  logic [NCH-1:0]    mOvf = '0;

  bit                  sRst;
  bit [NCH-1:0]        sVld;
  bit [NCH*DATA_W-1:0] sDin;
  bit                  sReq;
  bit [CW-1:0]         sRsel;
  bit                  sWreq;
  bit [CW-1:0]         sWsel;
  bit [DATA_W-1:0]     sWdata;
  bit [NCH-1:0]        sLb;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic clr();
    sRst = 0; sVld = '0; sDin = '0;
    sReq = 0; sRsel = '0;
    sWreq = 0; sWsel = '0; sWdata = '0; sLb = '0;
  endtask

  task automatic step();
    int popCh;
    int sz [NCH];
    bit psh;
    bit expStall;
    bit [NCH-1:0] lb;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    reset = sRst; port_in = sDin; port_in_vld = sVld;
    cpu_in_req = sReq; cpu_in_sel = sRsel;
    cpu_out_req = sWreq; cpu_out_sel = sWsel;
    cpu_out_data = sWdata;
`ifdef IO_LOOPBACK_EN
    loopback = sLb; lb = sLb;
`else
    lb = '0;
`endif
    #1;
    expStall = sReq && int'(sRsel) < NCH &&
               q[sRsel].size() == 0;
    chk("stall", {31'b0, cpu_in_stall}, {31'b0, expStall});
    if (sRst) begin
      for (int c = 0; c < NCH; c++) begin
        q[c].delete();
        mOut[c] = '0;
      end
      expQ.delete();
      mVld = '0;
      mOvf = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) sz[c] = q[c].size();
    popCh = -1;
    if (sReq && !expStall) begin
      if (int'(sRsel) < NCH) begin
        expQ.push_back(q[sRsel][0]);
        popCh = int'(sRsel);
        void'(q[sRsel].pop_front());
      end else begin
        expQ.push_back('0);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      psh = lb[c] ? (sWreq && int'(sWsel) == c) : sVld[c];
      d = lb[c] ? sWdata : sDin[c*DATA_W +: DATA_W];
      if (psh) begin
        if (sz[c] < DEPTH || popCh == c) q[c].push_back(d);
        else mOvf[c] = 1'b1;
      end
    end
    mVld = '0;
    if (sWreq && int'(sWsel) < NCH) begin
      mOut[sWsel] = sWdata;
      mVld[sWsel] = 1'b1;
    end
  endtask

  task automatic idle();
    clr();
    step();
  endtask

  task automatic pushCh(input int ch,
                        input logic [DATA_W-1:0] v);
    clr();
    sVld[ch] = 1'b1;
    sDin[ch*DATA_W +: DATA_W] = v;
    step();
  endtask

  task automatic readCh(input int ch);
    clr();
    sReq = 1'b1;
    sRsel = CW'(ch);
    step();
  endtask

  // monitor: scoreboard pop on ack, state compare every cycle
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_in_ack) begin
        if (expQ.size() == 0) begin
          chk("ackUnexpected", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          chk("rdData", {16'b0, cpu_in_data}, {16'b0, e});
        end
      end else if (expQ.size() != 0) begin
        chk("ackMissing", 32'd0, 32'd1);
        expQ.delete();
      end
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("count%0d", c),
            {29'b0, in_count[c*CNTW +: CNTW]},
            32'(q[c].size()));
        chk($sformatf("portOut%0d", c),
            {16'b0, port_out[c*DATA_W +: DATA_W]},
            {16'b0, mOut[c]});
      end
      chk("outVld", {29'b0, port_out_vld}, {29'b0, mVld});
      chk("ovf", {29'b0, ovf}, {29'b0, mOvf});
    end
  end

  initial begin
    reset = 1'b1; port_in = '0; port_in_vld = '0;
    cpu_in_req = 0; cpu_in_sel = '0;
    cpu_out_req = 0; cpu_out_sel = '0; cpu_out_data = '0;
`ifdef IO_LOOPBACK_EN
    loopback = '0;
`endif
    for (int c = 0; c < NCH; c++) mOut[c] = '0;

    clr(); sRst = 1; sVld = '1; sDin = '1; step(); step();
    idle();
    chk("rstCount", {23'b0, in_count}, 32'd0);
    chk("rstOut", {16'b0, port_out[DATA_W-1:0]}, 32'd0);
    chk("rstAck", {31'b0, cpu_in_ack}, 32'd0);

    pushCh(0, 16'h0005);
    pushCh(0, 16'h0019);
    readCh(0);
    readCh(0);
    idle();
    chk("readLast", {16'b0, cpu_in_data}, 32'h0019);

    readCh(1);
    clr(); sReq = 1; sRsel = 1;
    sVld[1] = 1; sDin[DATA_W +: DATA_W] = 16'hFFFF; step();
    readCh(1);
    idle();
    chk("readFFFF", {16'b0, cpu_in_data}, 32'hFFFF);

    for (int v = 1; v <= 5; v++) pushCh(0, DATA_W'(v));
    idle();
    chk("ovfFull", {31'b0, ovf[0]}, 32'd1);
    chk("cntFull", {29'b0, in_count[CNTW-1:0]}, 32'd4);
    for (int k = 0; k < 4; k++) readCh(0);
    idle();
    clr(); sRst = 1; step();
    for (int v = 1; v <= 4; v++) pushCh(0, DATA_W'(v));
    clr(); sReq = 1; sVld[0] = 1; sDin[DATA_W-1:0] = 16'd5;
    step();
    idle();
    chk("ovfPopFull", {31'b0, ovf[0]}, 32'd0);
    for (int k = 0; k < 4; k++) readCh(0);
    readCh(3);
    idle();

    clr(); sWreq = 1; sWsel = 1; sWdata = 16'hF320; step();
    idle();
    chk("out1", {16'b0, port_out[DATA_W +: DATA_W]},
        32'hF320);
    clr(); sWreq = 1; sWsel = 3; sWdata = 16'h1234; step();
    idle();

`ifdef IO_LOOPBACK_EN
    clr(); sRst = 1; step();
    clr(); sLb[0] = 1; sWreq = 1; sWsel = 0;
    sWdata = 16'h0320; sVld[0] = 1;
    sDin[DATA_W-1:0] = 16'hAAAA; step();
    idle();
    chk("lbOut", {16'b0, port_out[DATA_W-1:0]}, 32'h0320);
    chk("lbCnt", {29'b0, in_count[CNTW-1:0]}, 32'd1);
    readCh(0);
    idle();
    chk("lbRead", {16'b0, cpu_in_data}, 32'h0320);
`endif

    for (int n = 0; n < 3000; n++) begin
      clr();
      sRst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NCH; c++) begin
        sVld[c] = ($urandom_range(0, 2) == 0);
        sDin[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      sReq   = 1'($urandom_range(0, 1));
      sRsel  = CW'($urandom_range(0, 3));
      sWreq  = ($urandom_range(0, 2) == 0);
      sWsel  = CW'($urandom_range(0, 3));
      sWdata = DATA_W'($urandom);
      sLb    = NCH'($urandom);
      step();
    end

    idle(); idle(); idle();
    chk("pendingReads", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
Parametrised multi-channel I/O port controller between the pipeline processor's IN/OUT instructions and external pins. It generalises the single 16-bit portIn/portOut pair to NCH channels of DATA_W bits. Each input channel gets a strobe-qualified FIFO; each output channel gets a held register with a one-cycle valid pulse. The processor reads through a request/ack handshake with a stall output, and writes through a single-cycle request.

Parameters:
- DATA_W, 16, width of each port channel.
- NCH, 2, number of input and output channels (1..8).
- FIFO_DEPTH, 4, entries per input FIFO; power of 2, >= 2.
- CW, derived as max(1, clog2(NCH)); channel-select width.

Ports:
- clk, input, 1, system clock; rising edge.
- reset, input, 1, synchronous active-high reset.
- port_in, input, NCH*DATA_W, external input data; channel c occupies bits [c*DATA_W +: DATA_W].
- port_in_vld, input, NCH, per-channel sample strobe.
- port_out, output, NCH*DATA_W, held output registers.
- port_out_vld, output, NCH, one-cycle pulse on each output update.
- cpu_in_req, input, 1, IN instruction read request.
- cpu_in_sel, input, CW, channel to read.
- cpu_in_data, output, DATA_W, registered read data.
- cpu_in_ack, output, 1, read-complete pulse; cpu_in_data is valid in the same cycle.
- cpu_in_stall, output, 1, combinational stall while the selected FIFO is empty.
- cpu_out_req, input, 1, OUT instruction write request.
- cpu_out_sel, input, CW, channel to write.
- cpu_out_data, input, DATA_W, write data.
- in_count, output, NCH*(clog2(FIFO_DEPTH)+1), per-channel FIFO occupancy.
- ovf, output, NCH, sticky per-channel overflow flag.

Behaviour:
- Reset (synchronous, active-high) clears all FIFO pointers and counts, port_out, port_out_vld, cpu_in_data, cpu_in_ack and ovf to 0. Reset has priority over every other event in that cycle. A reset mid-handshake discards the pending read; no ack is issued.
- Input push:
  - If port_in_vld[c]=1 and FIFO c is not full, write the data and increment the count.
  - If FIFO c is full and no pop of channel c occurs in the same cycle, drop the data, set ovf[c]=1, and leave the count unchanged.
  - ovf[c] clears only on reset.
- Input read handshake:
  - In a cycle where cpu_in_req=1 and FIFO[cpu_in_sel] is non-empty, pop the head. On the next edge cpu_in_data takes the head value and cpu_in_ack pulses 1 for one cycle. Latency is one cycle.
  - cpu_in_stall = cpu_in_req & empty(FIFO[cpu_in_sel]), purely combinational. While it is high there is no pop and no ack; the requester holds req and sel.
  - Back-to-back reads: req held high pops one entry per cycle, giving one ack per cycle.
  - cpu_in_data holds its value when no ack occurs.
- Simultaneous push and pop on one channel:
  - Both take effect and the count is unchanged.
  - When full, the push is accepted because a slot frees; no ovf.
  - When empty, the push is accepted but the pop is not served (stall=1). There is no bypass; the data is readable the next cycle.
- cpu_in_sel >= NCH: no stall. The next cycle gives ack=1 with cpu_in_data=0, and no FIFO is touched.
- Output write:
  - cpu_out_req=1 with a valid cpu_out_sel loads port_out[sel] at the edge and pulses port_out_vld[sel] for one cycle.
  - Other channels hold their values.
  - Writing an out-of-range sel is ignored.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy ranges 0..FIFO_DEPTH inclusive.

Optional Feature:
- Macro: IO_LOOPBACK_EN.
- Defined:
  - Adds input port loopback, NCH bits wide.
  - While loopback[c]=1, a cpu_out write to channel c also pushes cpu_out_data into input FIFO c.
  - port_in_vld[c] is ignored for that channel. Full and ovf rules apply unchanged.
  - port_out and port_out_vld still update normally.
- Undefined: no loopback port, no loopback logic.

Test Plan:
1. Reset: assert reset for 2 cycles with port_in_vld=all 1s -> all counts 0, port_out=0, ovf=0, ack=0.
2. Push then read: channel 0 gets 16'h0005 then 16'h0019. Hold cpu_in_req with sel=0 for 2 cycles -> acks on consecutive cycles with data 0005 then 0019; count returns to 0; no stall.
3. Empty stall: cpu_in_req with sel=1 on an empty channel -> stall=1, no ack. Push 16'hFFFF on channel 1 -> stall drops the next cycle, ack follows one cycle later with data FFFF.
4. Overflow: push 5 values (1..5) into channel 0 with depth 4 -> count=4, ovf[0]=1 after the 5th push; reads return 1,2,3,4. Repeat with a simultaneous pop at full -> no ovf.
5. Output: cpu_out_req with sel=1 and data 16'hF320 -> the next cycle port_out ch1=F320 with port_out_vld=2'b10 for one cycle; ch0 unchanged. Out-of-range sel (NCH=3) -> no change.
6. Loopback (IO_LOOPBACK_EN defined): loopback[0]=1 and OUT 16'h0320 to ch0 -> port_out ch0=0320, in_count ch0=1; an IN from ch0 returns 0320; a concurrent port_in_vld[0] is ignored.
